// File: rtl/reconf_fir_engine.sv
// Reconfigurable FIR engine: NUM_BANK MAC lanes in parallel, each sweeping BANK_DEPTH taps per sample.
// Optional macro FIR_SAT_EN: clamp the narrowed result to the OUT_W range and pulse oOvf.
module reconf_fir_engine #(
   parameter int DATA_W     = 3,
   parameter int COEF_W     = 16,
   parameter int OUT_W      = 16,
   parameter int NUM_BANK   = 4,
   parameter int BANK_DEPTH = 10,
   parameter int OUT_SHIFT  = 0
) (
   input  logic                                   iClk12M,
   input  logic                                   iRst,
   input  logic                                   iEnSample,
   input  logic signed [DATA_W-1:0]               iFirIn,
   input  logic [$clog2(NUM_BANK+1)-1:0]          iBankCnt,
   input  logic                                   iCoeffWrEn,
   input  logic                                   iCoeffRdEn,
   input  logic [$clog2(NUM_BANK*BANK_DEPTH)-1:0] iCoeffAddr,
   input  logic signed [COEF_W-1:0]               iCoeffWtDt,
   output logic signed [COEF_W-1:0]               oCoeffRdDt,
   output logic                                   oCoeffRdVld,
   output logic                                   oCoeffWrErr,
   output logic signed [OUT_W-1:0]                oFirOut,
   output logic                                   oFirVld,
   output logic                                   oBusy,
   output logic                                   oSampleDrop,
   output logic                                   oOvf
);

   localparam int T      = NUM_BANK * BANK_DEPTH;
   localparam int AW     = $clog2(T);
   localparam int BCW    = $clog2(NUM_BANK + 1);
   localparam int KW     = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = PROD_W + $clog2(BANK_DEPTH);
   localparam int SUM_W  = ACC_W + $clog2(NUM_BANK);

   typedef enum logic [1:0] {StIdle, StCalc, StSum} state_e;

   state_e                   state_q;
   logic [KW-1:0]            k_q;
   logic [BCW-1:0]           n_q;
   logic signed [DATA_W-1:0] x_q   [T];
   logic signed [COEF_W-1:0] c_q   [T];
   logic signed [ACC_W-1:0]  acc_q [NUM_BANK];
   logic signed [ACC_W-1:0]  acc_d [NUM_BANK];
   logic signed [OUT_W-1:0]  fir_out_q;
   logic signed [COEF_W-1:0] rd_dt_q;
   logic                     fir_vld_q, rd_vld_q, wr_err_q, drop_q, ovf_q;

   logic signed [SUM_W-1:0]  sum, shifted;
   logic signed [OUT_W-1:0]  fir_res;
   logic                     ovf;
   logic                     addr_ok;
   logic [BCW-1:0]           n_clamp;

   assign addr_ok = {1'b0, iCoeffAddr} < (AW + 1)'(T);
   assign n_clamp = (iBankCnt == '0)            ? BCW'(1) :
                    (iBankCnt > BCW'(NUM_BANK)) ? BCW'(NUM_BANK) : iBankCnt;

   // Lane p works on tap p*BANK_DEPTH + k; the sum reads the settled accumulators in SUM.
   always_comb begin
      logic [AW-1:0]            idx;
      logic signed [PROD_W-1:0] prod;
      idx  = '0;
      prod = '0;
      sum  = '0;
      for (int p = 0; p < NUM_BANK; p++) begin
         idx      = AW'(p * BANK_DEPTH) + AW'(k_q);
         prod     = PROD_W'(x_q[idx]) * PROD_W'(c_q[idx]);
         acc_d[p] = acc_q[p] + ACC_W'(prod);
         sum      = sum + SUM_W'(acc_q[p]);
      end
      shifted = sum >>> OUT_SHIFT;
   end

`ifdef FIR_SAT_EN
   localparam logic signed [SUM_W-1:0] SatMax = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] SatMin = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   assign ovf     = (shifted > SatMax) || (shifted < SatMin);
   assign fir_res = (shifted > SatMax) ? OUT_W'(SatMax) :
                    (shifted < SatMin) ? OUT_W'(SatMin) : OUT_W'(shifted);
`else
   assign ovf     = 1'b0;
   assign fir_res = OUT_W'(shifted);
`endif

   always_ff @(posedge iClk12M or posedge iRst) begin
      if (iRst) begin
         state_q   <= StIdle;
         k_q       <= '0;
         n_q       <= '0;
         x_q       <= '{default: '0};
         c_q       <= '{default: '0};
         acc_q     <= '{default: '0};
         fir_out_q <= '0;
         fir_vld_q <= 1'b0;
         rd_dt_q   <= '0;
         rd_vld_q  <= 1'b0;
         wr_err_q  <= 1'b0;
         drop_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         fir_vld_q <= 1'b0;
         wr_err_q  <= 1'b0;
         drop_q    <= 1'b0;
         ovf_q     <= 1'b0;
         rd_vld_q  <= iCoeffRdEn;
         // Nonblocking read sees the pre-write value on a same-address read/write.
         if (iCoeffRdEn) begin
            rd_dt_q <= addr_ok ? c_q[iCoeffAddr] : '0;
         end
         if (iCoeffWrEn) begin
            if (state_q == StIdle && addr_ok) begin
               c_q[iCoeffAddr] <= iCoeffWtDt;
            end else begin
               wr_err_q <= 1'b1;
            end
         end
         if (iEnSample && state_q != StIdle) begin
            drop_q <= 1'b1;
         end
         case (state_q)
            StIdle: begin
               if (iEnSample) begin
                  for (int i = T - 1; i > 0; i--) begin
                     x_q[i] <= x_q[i-1];
                  end
                  x_q[0]  <= iFirIn;
                  n_q     <= n_clamp;
                  k_q     <= '0;
                  acc_q   <= '{default: '0};
                  state_q <= StCalc;
               end
            end
            StCalc: begin
               for (int p = 0; p < NUM_BANK; p++) begin
                  if (BCW'(p) < n_q) begin
                     acc_q[p] <= acc_d[p];
                  end
               end
               if (k_q == KW'(BANK_DEPTH - 1)) begin
                  state_q <= StSum;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            StSum: begin
               fir_out_q <= fir_res;
               fir_vld_q <= 1'b1;
               ovf_q     <= ovf;
               state_q   <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign oBusy       = (state_q != StIdle);
   assign oFirOut     = fir_out_q;
   assign oFirVld     = fir_vld_q;
   assign oCoeffRdDt  = rd_dt_q;
   assign oCoeffRdVld = rd_vld_q;
   assign oCoeffWrErr = wr_err_q;
   assign oSampleDrop = drop_q;
   assign oOvf        = ovf_q;

endmodule
